// File: rtl/instr_map_pkg.sv
// instr_map_pkg: RV32I opcode/funct constants and control-ROM indices shared by
// the address mapper and the control ROM.
package instr_map_pkg;

    typedef logic [5:0] map_addr_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Index 13 is reserved in the control ROM and is never produced.
    localparam map_addr_t MA_ILLEGAL = 6'd0;
    localparam map_addr_t MA_ADD     = 6'd1;
    localparam map_addr_t MA_SUB     = 6'd2;
    localparam map_addr_t MA_AND     = 6'd3;
    localparam map_addr_t MA_OR      = 6'd4;
    localparam map_addr_t MA_XOR     = 6'd5;
    localparam map_addr_t MA_SLL     = 6'd6;
    localparam map_addr_t MA_SRL     = 6'd7;
    localparam map_addr_t MA_SRA     = 6'd8;
    localparam map_addr_t MA_SLT     = 6'd9;
    localparam map_addr_t MA_SLTU    = 6'd10;
    localparam map_addr_t MA_LOAD    = 6'd11;
    localparam map_addr_t MA_STORE   = 6'd12;
    localparam map_addr_t MA_ADDI    = 6'd14;
    localparam map_addr_t MA_SLTI    = 6'd15;
    localparam map_addr_t MA_SLTIU   = 6'd16;
    localparam map_addr_t MA_XORI    = 6'd17;
    localparam map_addr_t MA_ORI     = 6'd18;
    localparam map_addr_t MA_ANDI    = 6'd19;
    localparam map_addr_t MA_SLLI    = 6'd20;
    localparam map_addr_t MA_SRLI    = 6'd21;
    localparam map_addr_t MA_SRAI    = 6'd22;
    localparam map_addr_t MA_LUI     = 6'd23;
    localparam map_addr_t MA_AUIPC   = 6'd24;
    localparam map_addr_t MA_JAL     = 6'd25;
    localparam map_addr_t MA_JALR    = 6'd26;

    typedef struct packed {
        map_addr_t   addr;
        logic [31:0] instr;
        logic [31:0] pc;
    } map_entry_t;

endpackage

// File: rtl/decode_skid_buf.sv
// decode_skid_buf: 2-entry skid buffer (main + skid register) with registered
// in_ready and synchronous flush.
module decode_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         r_main_valid;
    logic         r_skid_valid;
    logic [W-1:0] r_main_data;
    logic [W-1:0] r_skid_data;
    logic         w_accept;
    logic         w_load_main;

    assign w_accept    = in_valid && !r_skid_valid;
    assign w_load_main = !r_main_valid || out_ready;

    // Skid is only ever occupied while main is full, so main always takes skid first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_load_main) begin
            r_main_valid <= r_skid_valid || w_accept;
            r_main_data  <= r_skid_valid ? r_skid_data : w_accept ? in_data : r_main_data;
            r_skid_valid <= 1'b0;
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
        end
    end

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
endmodule

// File: rtl/instr_addr_mapper.sv
// instr_addr_mapper: maps RV32I words to control-ROM indices behind a skid buffer.
// Optional ILLEGAL_TRAP_EN adds the illegal flag and a saturating illegal counter.
module instr_addr_mapper
    import instr_map_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  mapped_address,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic        illegal,
    output logic [15:0] illegal_count
`endif
);
    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    map_addr_t  w_addr;
    map_entry_t w_in_entry;
    map_entry_t w_out_entry;

    assign w_opc = in_instr[6:0];
    assign w_f3  = in_instr[14:12];
    assign w_f7  = in_instr[31:25];

    always_comb begin
        w_addr = MA_ILLEGAL;
        case (w_opc)
            OPC_OP:
                case (w_f3)
                    F3_ADD_SUB: w_addr = w_f7 == F7_BASE ? MA_ADD : w_f7 == F7_ALT ? MA_SUB : MA_ILLEGAL;
                    F3_SR:      w_addr = w_f7 == F7_BASE ? MA_SRL : w_f7 == F7_ALT ? MA_SRA : MA_ILLEGAL;
                    default:    w_addr = w_f7 != F7_BASE ? MA_ILLEGAL :
                                         w_f3 == F3_AND  ? MA_AND :
                                         w_f3 == F3_OR   ? MA_OR :
                                         w_f3 == F3_XOR  ? MA_XOR :
                                         w_f3 == F3_SLL  ? MA_SLL :
                                         w_f3 == F3_SLT  ? MA_SLT : MA_SLTU;
                endcase
            OPC_OP_IMM:
                case (w_f3)
                    F3_ADD_SUB: w_addr = MA_ADDI;
                    F3_SLT:     w_addr = MA_SLTI;
                    F3_SLTU:    w_addr = MA_SLTIU;
                    F3_XOR:     w_addr = MA_XORI;
                    F3_OR:      w_addr = MA_ORI;
                    F3_SLL:     w_addr = w_f7 == F7_BASE ? MA_SLLI : MA_ILLEGAL;
                    F3_SR:      w_addr = w_f7 == F7_BASE ? MA_SRLI : w_f7 == F7_ALT ? MA_SRAI : MA_ILLEGAL;
                    default:    w_addr = MA_ANDI;
                endcase
            OPC_LOAD:  w_addr = MA_LOAD;
            OPC_STORE: w_addr = MA_STORE;
            OPC_LUI:   w_addr = MA_LUI;
            OPC_AUIPC: w_addr = MA_AUIPC;
            OPC_JAL:   w_addr = MA_JAL;
            OPC_JALR:  w_addr = w_f3 == F3_ADD_SUB ? MA_JALR : MA_ILLEGAL;
            default:   w_addr = MA_ILLEGAL;
        endcase
    end

    assign w_in_entry = '{addr: w_addr, instr: in_instr, pc: in_pc};

    decode_skid_buf #(.W($bits(map_entry_t))) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_entry)
    );

    assign mapped_address = w_out_entry.addr;
    assign out_instr      = w_out_entry.instr;
    assign out_pc         = w_out_entry.pc;

`ifdef ILLEGAL_TRAP_EN
    logic [15:0] r_illegal_count;

    assign illegal       = out_valid && (w_out_entry.addr == MA_ILLEGAL);
    assign illegal_count = r_illegal_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_illegal_count <= '0;
        else if (illegal && out_ready && r_illegal_count != 16'hFFFF)
            r_illegal_count <= r_illegal_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instr_addr_mapper.sv
// tb_instr_addr_mapper: table-driven mapping vectors plus hand-written stall,
// flush and asynchronous-reset sequences.
module tb_instr_addr_mapper;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  mapped_address;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
    logic [15:0] illegal_count;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int n_ill = 0;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  addr;
    } vec_t;

    vec_t vecs[31];

    localparam logic [31:0] I_ADD  = 32'h00208033;
    localparam logic [31:0] I_SUB  = 32'h40208033;
    localparam logic [31:0] I_AND  = 32'h0020F033;
    localparam logic [31:0] I_OR   = 32'h0020E033;
    localparam logic [31:0] I_XOR  = 32'h0020C033;
    localparam logic [31:0] I_SRAI = 32'h4010D093;

    always #5 clk = ~clk;

    instr_addr_mapper dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .mapped_address (mapped_address),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal        (illegal),
        .illegal_count  (illegal_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        @(negedge clk);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        vecs[0]  = '{I_ADD, 6'd1};
        vecs[1]  = '{I_SUB, 6'd2};
        vecs[2]  = '{I_AND, 6'd3};
        vecs[3]  = '{I_OR, 6'd4};
        vecs[4]  = '{I_XOR, 6'd5};
        vecs[5]  = '{32'h00209033, 6'd6};
        vecs[6]  = '{32'h0020D033, 6'd7};
        vecs[7]  = '{32'h4020D033, 6'd8};
        vecs[8]  = '{32'h0020A033, 6'd9};
        vecs[9]  = '{32'h0020B033, 6'd10};
        vecs[10] = '{I_SRAI, 6'd22};
        vecs[11] = '{32'h0000A103, 6'd11};
        vecs[12] = '{32'h00000067, 6'd26};
        vecs[13] = '{32'h0020A023, 6'd12};
        vecs[14] = '{32'h00100093, 6'd14};
        vecs[15] = '{32'h0010A093, 6'd15};
        vecs[16] = '{32'h0010B093, 6'd16};
        vecs[17] = '{32'h0010C093, 6'd17};
        vecs[18] = '{32'h0010E093, 6'd18};
        vecs[19] = '{32'h0010F093, 6'd19};
        vecs[20] = '{32'h00109093, 6'd20};
        vecs[21] = '{32'h0010D093, 6'd21};
        vecs[22] = '{32'h000010B7, 6'd23};
        vecs[23] = '{32'h00001097, 6'd24};
        vecs[24] = '{32'h0000306F, 6'd25};
        vecs[25] = '{32'h00000000, 6'd0};
        vecs[26] = '{32'h02208033, 6'd0};
        vecs[27] = '{32'h00001067, 6'd0};
        vecs[28] = '{32'h40109093, 6'd0};
        vecs[29] = '{32'h0020F032, 6'd0};
        vecs[30] = '{32'h4020F033, 6'd0};

        repeat (2) step();
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset mapped", 32'(mapped_address), 0);
        @(negedge clk);
        rst_n = 1'b1;

        out_ready = 1'b1;
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, vecs[i].instr, 32'h1000 + 32'(i) * 4);
            step();
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 1);
            chk($sformatf("vec%0d mapped", i), 32'(mapped_address), 32'(vecs[i].addr));
            chk($sformatf("vec%0d out_instr", i), out_instr, vecs[i].instr);
            chk($sformatf("vec%0d out_pc", i), out_pc, 32'h1000 + 32'(i) * 4);
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 1);
`ifdef ILLEGAL_TRAP_EN
            chk($sformatf("vec%0d illegal", i), 32'(illegal), 32'(vecs[i].addr == 6'd0));
`endif
            if (vecs[i].addr == 6'd0) n_ill++;
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("table drain out_valid", 32'(out_valid), 0);
`ifdef ILLEGAL_TRAP_EN
        chk("illegal_count", 32'(illegal_count), 32'(n_ill));
`endif

        // stall: two accepted, third held, then released in order
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h2000;
        step();
        chk("stall1 mapped", 32'(mapped_address), 1);
        chk("stall1 in_ready", 32'(in_ready), 1);
        drive(1'b1, I_SUB, 32'h2004);
        step();
        chk("stall2 mapped held", 32'(mapped_address), 1);
        chk("stall2 in_ready", 32'(in_ready), 0);
        drive(1'b1, I_AND, 32'h2008);
        step();
        chk("stall3 out_pc held", out_pc, 32'h2000);
        chk("stall3 in_ready", 32'(in_ready), 0);
        @(negedge clk);
        out_ready = 1'b1;
        step();
        chk("release1 mapped", 32'(mapped_address), 2);
        chk("release1 out_pc", out_pc, 32'h2004);
        chk("release1 in_ready", 32'(in_ready), 1);
        step();
        chk("release2 mapped", 32'(mapped_address), 3);
        chk("release2 out_pc", out_pc, 32'h2008);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("release3 out_valid", 32'(out_valid), 0);

        // flush with both entries full
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h4000;
        step();
        drive(1'b1, I_SUB, 32'h4004);
        step();
        chk("flushA full in_ready", 32'(in_ready), 0);
        drive(1'b1, I_OR, 32'h4008);
        flush = 1'b1;
        step();
        chk("flushA out_valid", 32'(out_valid), 0);
        chk("flushA in_ready", 32'(in_ready), 1);
        drive(1'b0, 32'h0, 32'h0);
        flush = 1'b0;
        step();
        chk("flushA dropped", 32'(out_valid), 0);

        // flush beats a same-cycle accept while skid is empty
        drive(1'b1, I_ADD, 32'h5000);
        step();
        chk("flushB main", 32'(out_valid), 1);
        drive(1'b1, I_XOR, 32'h5004);
        flush = 1'b1;
        step();
        chk("flushB out_valid", 32'(out_valid), 0);
        chk("flushB in_ready", 32'(in_ready), 1);
        drive(1'b0, 32'h0, 32'h0);
        flush = 1'b0;
        step();
        chk("flushB dropped", 32'(out_valid), 0);

        // asynchronous reset mid-stall
        drive(1'b1, I_ADD, 32'h6000);
        step();
        drive(1'b1, I_SUB, 32'h6004);
        step();
        drive(1'b0, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset out_valid", 32'(out_valid), 0);
        chk("areset mapped", 32'(mapped_address), 0);
        chk("areset out_instr", out_instr, 0);
        chk("areset out_pc", out_pc, 0);
        chk("areset in_ready", 32'(in_ready), 1);
`ifdef ILLEGAL_TRAP_EN
        chk("areset illegal_count", 32'(illegal_count), 0);
`endif
        drive(1'b1, I_SRAI, 32'h3000);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post-reset mapped", 32'(mapped_address), 22);
        chk("post-reset out_pc", out_pc, 32'h3000);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("post-reset drain", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
